// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, halt encoding and fetch FSM state type.
// Also used by the instruction ROM and the decoder.
package cpu_pkg;

  localparam int PC_W   = 8;
  localparam int INST_W = 9;

  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [INST_W-1:0] inst_t;

  // All-ones word halts execution; it is also what unprogrammed ROM addresses return.
  localparam inst_t HALT_INST = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Program counter and fetch control: sequences the instruction ROM from a start
// pulse, applies taken branches, honours stalls and stops on the halt word.
//
// state  | meaning
// IDLE   | out of reset, PC parked at RESET_PC, waiting for start
// RUN    | one instruction per unstalled cycle, PC advances or branches
// HALTED | halt word seen, PC and count frozen, start restarts
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                PC_W_P    = PC_W,
  parameter int                INST_W_P  = INST_W,
  parameter logic [PC_W_P-1:0] RESET_PC  = '0,
  parameter logic [INST_W_P-1:0] HALT_W  = '1,
  parameter int                CNT_W     = 16
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                branch_take,
  input  logic [PC_W_P-1:0]   branch_target,
  input  logic [INST_W_P-1:0] inst,
  output logic [PC_W_P-1:0]   PC,
  output logic                running,
  output logic                halt,
  output logic                done,
  output logic [CNT_W-1:0]    inst_count
);

  fetch_state_t        state_q, state_d;
  logic [PC_W_P-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Stall outranks everything, including a halt word already on the bus.
        if (!stall) begin
          if (inst == HALT_W) begin
            state_d = HALTED;
            done_d  = 1'b1;
          end else begin
            pc_d  = branch_take ? branch_target : pc_q + PC_W_P'(1);
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign PC         = pc_q;
  assign running    = (state_q == RUN);
  assign halt       = (state_q == HALTED);
  assign done       = done_q;
  assign inst_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model pushes expected outputs
// per driven cycle; they are popped and compared one edge later.
module tb_fetch_unit;

  logic       CLK;
  logic       reset, start, stall, branch_take;
  logic [7:0] branch_target;
  logic [8:0] inst;
  logic [7:0] PC;
  logic       running, halt, done;
  logic [15:0] inst_count;

  logic [7:0] pc4;
  logic       running4, halt4, done4;
  logic [3:0] inst_count4;

  logic [8:0] rom [256];

  fetch_unit dut (
    .CLK(CLK), .reset(reset), .start(start), .stall(stall),
    .branch_take(branch_take), .branch_target(branch_target), .inst(inst),
    .PC(PC), .running(running), .halt(halt), .done(done), .inst_count(inst_count)
  );

  // Narrow counter copy fed nothing but non-halt words, so it only saturates.
  fetch_unit #(.CNT_W(4)) dut4 (
    .CLK(CLK), .reset(reset), .start(start), .stall(stall),
    .branch_take(1'b0), .branch_target(8'h00), .inst(9'h000),
    .PC(pc4), .running(running4), .halt(halt4), .done(done4), .inst_count(inst_count4)
  );

  assign inst = rom[PC];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [7:0]  pc;
    logic        running;
    logic        halt;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // model state: 0 idle, 1 run, 2 halted
  int          m_st  = 0;
  logic [7:0]  m_pc  = 8'h00;
  logic [15:0] m_cnt = 16'h0000;
  logic        m_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic st, input logic stl,
                            input logic bt, input logic [7:0] tgt);
    logic [8:0] w;
    w = rom[m_pc];
    if (rst) begin
      m_st = 0; m_pc = 8'h00; m_cnt = 16'h0000; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_st == 1) begin
        if (!stl) begin
          if (w == 9'h1FF) begin
            m_st = 2; m_done = 1'b1;
          end else begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (bt) m_pc = tgt;
            else    m_pc = m_pc + 8'd1;
          end
        end
      end else if (st) begin
        m_st = 1; m_pc = 8'h00; m_cnt = 16'h0000;
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic st, input logic stl,
                     input logic bt, input logic [7:0] tgt);
    exp_t e;
    @(negedge CLK);
    reset = rst; start = st; stall = stl; branch_take = bt; branch_target = tgt;
    model_step(rst, st, stl, bt, tgt);
    e.pc = m_pc; e.running = (m_st == 1); e.halt = (m_st == 2);
    e.done = m_done; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check("pc",      32'(PC),         32'(e.pc));
    check("running", 32'(running),    32'(e.running));
    check("halt",    32'(halt),       32'(e.halt));
    check("done",    32'(done),       32'(e.done));
    check("count",   32'(inst_count), 32'(e.cnt));
  endtask

  task automatic rom_fill(input int last_nop);
    for (int i = 0; i < 256; i++) rom[i] = (i <= last_nop) ? 9'h001 : 9'h1FF;
  endtask

  // Run until the model halts; branch once when the model PC equals br_at.
  task automatic run_to_halt(input int maxc, input int br_at, input logic [7:0] tgt);
    bit br_used = 0;
    bit fired;
    for (int c = 0; c < maxc && m_st != 2; c++) begin
      fired = (!br_used && br_at >= 0 && int'(m_pc) == br_at);
      if (fired) br_used = 1;
      cyc(1'b0, 1'b0, 1'b0, fired, fired ? tgt : 8'h00);
      if (fired) check("branch_pc", 32'(PC), 32'(tgt));
    end
    check("halt_reached", 32'(halt), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_take = 1'b0; branch_target = 8'h00;
    rom_fill(2);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // three nops then halt word at 3
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    run_to_halt(20, -1, 8'h00);
    check("t1_count", 32'(inst_count), 32'd3);
    check("t1_pc",    32'(PC),         32'd3);

    // branch at 5 to 40; 41 holds the halt word
    rom_fill(5); rom[40] = 9'h002;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("t2_restart_pc", 32'(PC), 32'd0);
    run_to_halt(30, 5, 8'd40);
    check("t2_count", 32'(inst_count), 32'd7);

    // stall at PC 10 with a pending branch to 50
    rom_fill(10);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 30 && m_pc != 8'd10; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t3_at10", 32'(PC), 32'd10);
    for (int c = 0; c < 4; c++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'd50);
    check("t3_stall_pc",  32'(PC),         32'd10);
    check("t3_stall_cnt", 32'(inst_count), 32'd10);
    run_to_halt(10, 10, 8'd50);
    check("t3_count", 32'(inst_count), 32'd11);

    // wrap 255 -> 0, halt word at 1
    rom_fill(255); rom[1] = 9'h1FF;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    run_to_halt(30, 0, 8'd250);
    check("t4_pc",    32'(PC),         32'd1);
    check("t4_count", 32'(inst_count), 32'd8);

    // restart from HALTED, then reset two cycles into a stall
    rom_fill(255);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("t5_restart_cnt", 32'(inst_count), 32'd0);
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    check("t5_rst_running", 32'(running), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t5_idle_pc", 32'(PC), 32'd0);

    // 4-bit counter saturation on the narrow instance
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("t6_cnt4_start", 32'(inst_count4), 32'd0);
    for (int c = 0; c < 10; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t6_cnt4_10", 32'(inst_count4), 32'd10);
    for (int c = 0; c < 10; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t6_cnt4_sat", 32'(inst_count4), 32'd15);
    check("t6_pc4", 32'(pc4), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch-control stage sitting directly upstream of the instruction ROM: it owns the 8-bit PC that addresses instruction memory and receives the 9-bit instruction word back. It sequences execution from a start pulse, applies taken branches from the decoder, honours pipeline stalls, and detects the all-ones halt word. It reports halt/done to the testbench and counts executed instructions.

## Interface
- `PC_W`, 8, PC / ROM address width
- `INST_W`, 9, instruction width
- `RESET_PC`, 0, PC loaded on reset and on start
- `HALT_INST`, 9'b111_111_111, halt encoding (also the ROM default for unlisted addresses)
- `CNT_W`, 16, executed-instruction counter width
- `CLK`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin execution at `RESET_PC` (level sampled each cycle)
- `stall`  in  1  freeze PC and counter this cycle
- `branch_take`  in  1  decoder: current instruction is a taken branch
- `branch_target`  in  PC_W  absolute branch destination
- `inst`  in  INST_W  instruction word returned by ROM for current `PC`
- `PC`  out  PC_W  registered fetch address
- `running`  out  1  high while in RUN
- `halt`  out  1  level, high while in HALTED
- `done`  out  1  one-cycle pulse on entry to HALTED
- `inst_count`  out  CNT_W  instructions executed since last start

## Operation
- States: IDLE, RUN, HALTED. Reset → IDLE.
- IDLE: PC holds `RESET_PC`; `start`=1 → RUN, PC=`RESET_PC`, `inst_count`=0.
- RUN, per cycle, priority order:
  1. `stall`=1: PC, counter, state unchanged; `branch_take`/`inst` ignored.
  2. `inst`==`HALT_INST`: → HALTED; PC holds (points at halt word); halt word not counted.
  3. `branch_take`=1: PC ← `branch_target`; counter +1.
  4. Otherwise PC ← PC+1 modulo 2^PC_W (255 → 0, no flag); counter +1.
- `start` in RUN is ignored.
- HALTED: PC and counter frozen; `start`=1 → RUN, PC=`RESET_PC`, counter=0, `halt` drops.
- `inst_count` saturates at all-ones; never wraps.
- `running` = (state==RUN); `halt` = (state==HALTED); both decoded from registered state.

## Timing
- Reset values: PC=`RESET_PC`, running=0, halt=0, done=0, inst_count=0, state=IDLE. Reset mid-RUN or mid-stall aborts immediately; same values next cycle.
- `start` sampled at edge N → `running`=1 and PC=`RESET_PC` in cycle N+1.
- ROM is combinational: `inst` for `PC` is valid within the same cycle; unit decides next PC from it at the next edge.
- Sequential or branch: one instruction per cycle; branch taken at edge N → PC=`branch_target` in N+1 (zero bubbles).
- Halt word present at edge N → `halt`=1 and `done`=1 in N+1; `done`=0 in N+2 onward.
- Stall plus halt word same cycle: stall wins; halt detected on first unstalled edge.
- Branch plus halt word same cycle: halt wins.

## Structure
- Shared package `cpu_pkg`: `PC_W`, `INST_W`, `HALT_INST`, `fetch_state_t` enum (IDLE/RUN/HALTED), PC and instruction typedefs; also used by ROM and decoder.
- Single flat module; no sub-module needed. Counter and next-PC mux inline.

## Test plan
- Reset then `start` pulse, ROM with 3 non-branch words then halt at 3 → PC 0,1,2,3; `done` pulse one cycle after PC=3; `inst_count`=3; `halt` held.
- `branch_take`=1, target 40, at PC=5 → PC=40 next cycle; count increments by 1 for the branch.
- `stall` high 4 cycles at PC=10 with `branch_take` asserted → PC stays 10, count frozen; on release, branch to target applied.
- Straight-line code through PC=255 → PC wraps to 0; halt-filled address reached → HALTED.
- Assert `reset` two cycles into a stall in RUN → next cycle all outputs at reset values, state IDLE; `start` from HALTED restarts at PC=0, count 0.
- Force `CNT_W`=4, run 20 non-halt instructions → `inst_count` sticks at 15.
